// File: rtl/osmanip_step_decoder.sv
// Receive-side decoder for the osmanip motor interface: turns step/dir strobes
// into per-motor quarter-turn events delivered through a FWFT valid/ready FIFO.
module osmanip_step_decoder #(
    parameter int unsigned STEPS_PER_QTURN = 50,
    parameter int unsigned IDLE_TIMEOUT    = 5000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       i_mxa,
    input  logic       i_mxb,
    input  logic       i_mya,
    input  logic       i_myb,
    input  logic       i_mza,
    input  logic       i_mzb,
    input  logic       i_dira,
    input  logic       i_dirb,
    output logic       o_move_valid,
    output logic [3:0] o_move_data,
    input  logic       i_move_ready,
    output logic       o_overflow,
    output logic       o_partial_err,
    output logic [2:0] o_err_motor,
    input  logic       i_clear
);

    localparam int unsigned NM = 6;
    localparam int unsigned CW = $clog2(STEPS_PER_QTURN) + 1;
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = AW + 1;

    // Limits are checked one step early so the counter never has to hold +/-STEPS.
    localparam logic [CW-1:0] LIM_P     = CW'(STEPS_PER_QTURN - 1);
    localparam logic [CW-1:0] LIM_N     = CW'(0) - LIM_P;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

    logic [7:0]    raw_c;
    logic [7:0]    sync1_q, sync2_q;
    logic [5:0]    sync3_q;
    logic [NM-1:0] step_q, step_d;
    logic [1:0]    sdir_q, sdir_d;

    logic [CW-1:0] cnt_q  [NM];
    logic [CW-1:0] cnt_d  [NM];
    logic [IW-1:0] idle_q [NM];
    logic [IW-1:0] idle_d [NM];
    logic [NM-1:0] pend_q, pend_d, pdir_q, pdir_d;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0] cnt_f_q, cnt_f_d;
    logic          valid_q, valid_d;
    logic [3:0]    head_q, head_d;

    logic          ovf_q, ovf_d, perr_q, perr_d;
    logic [2:0]    emot_q, emot_d;

    logic [NM-1:0] comp_c, cdir_c, to_c, served_c;
    logic          dir_c, drop_c, push_c, pop_c, accept_c, err_base_c;
    logic [2:0]    sel_c;
    logic [3:0]    push_data_c;

    assign raw_c = {i_dirb, i_dira, i_mzb, i_mza, i_myb, i_mya, i_mxb, i_mxa};

    always_comb begin
        step_d     = sync2_q[5:0] & ~sync3_q;
        sdir_d     = sync2_q[7:6];
        comp_c     = '0;
        cdir_c     = '0;
        to_c       = '0;
        served_c   = '0;
        dir_c      = 1'b0;
        drop_c     = 1'b0;
        sel_c      = 3'd0;
        pend_d     = pend_q;
        pdir_d     = pdir_q;
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_f_d    = cnt_f_q;
        ovf_d      = i_clear ? 1'b0 : ovf_q;
        err_base_c = i_clear ? 1'b0 : perr_q;
        perr_d     = err_base_c;
        emot_d     = i_clear ? 3'd0 : emot_q;

        // Per-motor step accumulation and idle timeout; a step always beats a timeout.
        for (int m = 0; m < NM; m++) begin
            cnt_d[m]  = cnt_q[m];
            idle_d[m] = idle_q[m];
            dir_c     = (m % 2 == 1) ? sdir_q[1] : sdir_q[0];
            if (step_q[m]) begin
                idle_d[m] = '0;
                if (dir_c && cnt_q[m] == LIM_P) begin
                    cnt_d[m]  = '0;
                    comp_c[m] = 1'b1;
                    cdir_c[m] = 1'b1;
                end else if (!dir_c && cnt_q[m] == LIM_N) begin
                    cnt_d[m]  = '0;
                    comp_c[m] = 1'b1;
                end else begin
                    cnt_d[m] = dir_c ? cnt_q[m] + CW'(1) : cnt_q[m] - CW'(1);
                end
            end else if (cnt_q[m] != '0) begin
                if (idle_q[m] == IDLE_LAST) begin
                    cnt_d[m]  = '0;
                    idle_d[m] = '0;
                    to_c[m]   = 1'b1;
                end else begin
                    idle_d[m] = idle_q[m] + IW'(1);
                end
            end else begin
                idle_d[m] = '0;
            end
        end

        for (int m = NM - 1; m >= 0; m--) begin
            if (pend_q[m]) begin
                sel_c = 3'(m);
            end
        end
        pop_c       = valid_q & i_move_ready;
        accept_c    = (cnt_f_q != FULL_CNT) | pop_c;
        push_c      = (|pend_q) & accept_c;
        push_data_c = {pdir_q[sel_c], sel_c};
        if (push_c) begin
            served_c[sel_c] = 1'b1;
        end
        pend_d = pend_q & ~served_c;

        // A completion landing on a still-pending motor is lost.
        for (int m = 0; m < NM; m++) begin
            if (comp_c[m]) begin
                if (pend_q[m]) begin
                    drop_c = 1'b1;
                end else begin
                    pend_d[m] = 1'b1;
                    pdir_d[m] = cdir_c[m];
                end
            end
        end
        if (drop_c) begin
            ovf_d = 1'b1;
        end

        if (|to_c && !err_base_c) begin
            perr_d = 1'b1;
            for (int m = NM - 1; m >= 0; m--) begin
                if (to_c[m]) begin
                    emot_d = 3'(m);
                end
            end
        end

        if (push_c) begin
            mem_d[wr_q] = push_data_c;
            wr_d        = wr_q + AW'(1);
        end
        if (pop_c) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_f_d = cnt_f_q + NW'(push_c) - NW'(pop_c);
        valid_d = (cnt_f_d != '0);
        head_d  = valid_d ? mem_d[rd_d] : 4'd0;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            step_q  <= '0;
            sdir_q  <= '0;
            for (int m = 0; m < NM; m++) begin
                cnt_q[m]  <= '0;
                idle_q[m] <= '0;
            end
            pend_q  <= '0;
            pdir_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_f_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            emot_q  <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q[5:0];
            step_q  <= step_d;
            sdir_q  <= sdir_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            pend_q  <= pend_d;
            pdir_q  <= pdir_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_f_q <= cnt_f_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            emot_q  <= emot_d;
        end
    end

    assign o_move_valid  = valid_q;
    assign o_move_data   = head_q;
    assign o_overflow    = ovf_q;
    assign o_partial_err = perr_q;
    assign o_err_motor   = emot_q;

endmodule
